// File: rtl/mul_seq.sv
// mul_seq: sequences framed 8-bit operands from a small FIFO into a 16-bit multiply-accumulate stage
// and presents each frame's truncated product (plus operand count) on a valid/ready result port.

module mul_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       mul_a,
  output logic             mul_ce,
  output logic             mul_init,
  input  logic [15:0]      mul_acc,
  output logic [15:0]      res_data,
  output logic [CNT_W-1:0] res_count,
  output logic             res_valid,
  input  logic             res_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]      LP_FILL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      LP_FILL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    LP_PTR_ONE   = AW'(1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DRAIN,
    S_CAPT,
    S_HOLD
  } state_t;

  // Operand FIFO: each entry is {last, data}
  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_fill;
  logic          r_full;
  logic          r_empty;

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_fill_next;
  logic [8:0]    w_rd_entry;

  // Sequencer state
  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_mul_a;
  logic [7:0]       w_mul_a_next;
  logic             r_mul_ce;
  logic             w_mul_ce_next;
  logic             w_mul_init;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [15:0]      r_res_data;
  logic [15:0]      w_res_data_next;
  logic [CNT_W-1:0] r_res_count;
  logic [CNT_W-1:0] w_res_count_next;
  logic             r_res_valid;
  logic             w_res_valid_next;

  // in_ready only looks at the registered full flag so it never depends on this cycle's pop
  assign in_ready   = nReset & ~r_full;
  assign w_push     = in_valid & in_ready;
  assign w_rd_entry = r_mem[r_rd_ptr];

  always_comb begin
    w_fill_next = r_fill;
    case ({w_push, w_pop})
      2'b10:   w_fill_next = r_fill + LP_FILL_ONE;
      2'b01:   w_fill_next = r_fill - LP_FILL_ONE;
      default: w_fill_next = r_fill;
    endcase
  end

  // Storage has no reset: stale entries are unreachable once the pointers are cleared
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_last, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
      r_fill  <= w_fill_next;
      r_full  <= (w_fill_next == LP_FILL_FULL);
      r_empty <= (w_fill_next == '0);
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_pop            = 1'b0;
    w_mul_init       = 1'b0;
    w_mul_a_next     = r_mul_a;
    w_mul_ce_next    = 1'b0;
    w_cnt_next       = r_cnt;
    w_res_data_next  = r_res_data;
    w_res_count_next = r_res_count;
    w_res_valid_next = r_res_valid;

    case (r_state)
      S_IDLE: begin
        if (!r_empty) begin
          w_state_next = S_INIT;
        end
      end

      S_INIT: begin
        w_mul_init   = 1'b1;
        w_cnt_next   = '0;
        w_state_next = S_RUN;
      end

      S_RUN: begin
        // An empty FIFO mid-frame just inserts a bubble; mul_a keeps its last value
        if (!r_empty) begin
          w_pop         = 1'b1;
          w_mul_a_next  = w_rd_entry[7:0];
          w_mul_ce_next = 1'b1;
          if (r_cnt != LP_CNT_MAX) begin
            w_cnt_next = r_cnt + LP_CNT_ONE;
          end
          if (w_rd_entry[8]) begin
            w_state_next = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        w_state_next = S_CAPT;
      end

      S_CAPT: begin
        w_res_data_next  = mul_acc;
        w_res_count_next = r_cnt;
        w_res_valid_next = 1'b1;
        w_state_next     = S_HOLD;
      end

      S_HOLD: begin
        if (res_ready) begin
          w_res_valid_next = 1'b0;
          w_state_next     = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_state     <= S_IDLE;
      r_mul_a     <= '0;
      r_mul_ce    <= 1'b0;
      r_cnt       <= '0;
      r_res_data  <= '0;
      r_res_count <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mul_a     <= w_mul_a_next;
      r_mul_ce    <= w_mul_ce_next;
      r_cnt       <= w_cnt_next;
      r_res_data  <= w_res_data_next;
      r_res_count <= w_res_count_next;
      r_res_valid <= w_res_valid_next;
    end
  end

  assign mul_a     = r_mul_a;
  assign mul_ce    = r_mul_ce;
  assign mul_init  = w_mul_init;
  assign res_data  = r_res_data;
  assign res_count = r_res_count;
  assign res_valid = r_res_valid;

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: drives framed operands into mul_seq with a behavioural multiply stage attached
// and compares each captured product against a frame-level arithmetic model.

module tb_mul_seq;

  localparam int CNT_W = 8;
  localparam int MAXC  = 16384;
  localparam int NF    = 25;

  logic             clk = 1'b0;
  logic             nReset = 1'b0;
  logic [7:0]       in_data = '0;
  logic             in_last = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       mul_a;
  logic             mul_ce;
  logic             mul_init;
  logic [15:0]      acc;
  logic [15:0]      res_data;
  logic [CNT_W-1:0] res_count;
  logic             res_valid;
  logic             res_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int overlap_cnt = 0;
  bit ce_log   [MAXC];
  bit init_log [MAXC];

  always #5 clk = ~clk;

  mul_seq #(.DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mul_a     (mul_a),
    .mul_ce    (mul_ce),
    .mul_init  (mul_init),
    .mul_acc   (acc),
    .res_data  (res_data),
    .res_count (res_count),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  // Multiply-accumulate stage: load 1 on init, otherwise acc = (a * acc) mod 2^16
  always @(posedge clk) begin
    if (!nReset) acc <= 16'h0000;
    else if (mul_init) acc <= 16'h0001;
    else if (mul_ce) acc <= acc * {8'h00, mul_a};
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      ce_log[cyc]   <= mul_ce;
      init_log[cyc] <= mul_init;
    end
    if (nReset && mul_ce && mul_init) overlap_cnt <= overlap_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: frame product truncated to 16 bits, count saturating at 2^CNT_W-1
  function automatic logic [15:0] ref_prod(input int ops[$]);
    int p;
    p = 1;
    foreach (ops[i]) p = (p * ops[i]) % 65536;
    return 16'(p);
  endfunction

  function automatic logic [CNT_W-1:0] ref_cnt(input int n);
    int mx;
    mx = (1 << CNT_W) - 1;
    return (n > mx) ? CNT_W'(mx) : CNT_W'(n);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_one(input logic [7:0] d, input logic l, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (in_ready) begin
      step();
      ok = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int ops[$], output bit ok);
    bit one_ok;
    ok = 1'b1;
    foreach (ops[i]) begin
      push_one(8'(ops[i]), (i == ops.size() - 1), one_ok);
      if (!one_ok) ok = 1'b0;
    end
  endtask

  task automatic wait_result(input int bound, output bit ok, output logic [15:0] d,
                             output logic [CNT_W-1:0] c, output int vc);
    int n;
    n = 0;
    ok = 1'b0;
    d = '0;
    c = '0;
    vc = 0;
    while (!res_valid && n < bound) begin
      step();
      n++;
    end
    if (res_valid) begin
      ok = 1'b1;
      d = res_data;
      c = res_count;
      vc = cyc;
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, mul_a, mul_ce, mul_init, res_data, res_count, res_valid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%0b mul_a=%0h ce=%0b init=%0b res=%0h cnt=%0d valid=%0b, all must be 0",
               in_ready, mul_a, mul_ce, mul_init, res_data, res_count, res_valid);
    end
    nReset = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || mul_ce !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%0b res_valid=%0b mul_ce=%0b, required 1/0/0", in_ready, res_valid, mul_ce);
    end
  endtask

  task automatic test_basic();
    int q[$];
    bit ok;
    logic [15:0] d;
    logic [CNT_W-1:0] c;
    int vc, start, inits, init_at, first_ce, last_ce, ce_cnt;
    q.push_back(3); q.push_back(5); q.push_back(7);
    res_ready = 1'b1;
    start = cyc;
    send_frame(q, ok);
    wait_result(50, ok, d, c, vc);
    checks++;
    if (!ok || d !== ref_prod(q) || c !== ref_cnt(q.size())) begin
      errors++;
      $display("FAIL basic_result: ok=%0b data=%0d count=%0d, required data=%0d count=%0d", ok, d, c, ref_prod(q), ref_cnt(q.size()));
    end
    step();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_consumed: res_valid=%0b, required 0 after handshake", res_valid);
    end
    inits = 0; init_at = -1; first_ce = -1; last_ce = -1; ce_cnt = 0;
    for (int i = start; i <= vc && i < MAXC; i++) begin
      if (init_log[i]) begin inits++; init_at = i; end
      if (ce_log[i]) begin
        if (first_ce < 0) first_ce = i;
        last_ce = i;
        ce_cnt++;
      end
    end
    checks++;
    if (inits != 1 || init_at < 0 || first_ce < 0 || init_at >= first_ce) begin
      errors++;
      $display("FAIL basic_init_pulse: pulses=%0d at=%0d first_ce=%0d, required one pulse before first mul_ce", inits, init_at, first_ce);
    end
    checks++;
    if (ce_cnt != 3) begin
      errors++;
      $display("FAIL basic_ce_count: mul_ce cycles=%0d, required 3", ce_cnt);
    end
    // The final operand's mul_ce cycle is one after its pop, so valid lands two cycles later
    checks++;
    if (vc - last_ce != 2) begin
      errors++;
      $display("FAIL basic_latency: res_valid at %0d final mul_ce at %0d (diff %0d), required diff 2", vc, last_ce, vc - last_ce);
    end
  endtask

  task automatic test_truncate();
    int q[$];
    bit ok;
    logic [15:0] d;
    logic [CNT_W-1:0] c;
    int vc;
    repeat (4) q.push_back(16);
    res_ready = 1'b1;
    send_frame(q, ok);
    wait_result(50, ok, d, c, vc);
    checks++;
    if (!ok || d !== ref_prod(q) || c !== ref_cnt(q.size())) begin
      errors++;
      $display("FAIL truncate_result: ok=%0b data=%0h count=%0d, required data=%0h count=%0d", ok, d, c, ref_prod(q), ref_cnt(q.size()));
    end
    step();
  endtask

  task automatic test_single_hold();
    int q[$];
    bit ok;
    logic [15:0] d;
    logic [CNT_W-1:0] c;
    int vc, bad;
    q.push_back(255);
    res_ready = 1'b0;
    send_frame(q, ok);
    wait_result(50, ok, d, c, vc);
    checks++;
    if (!ok || d !== ref_prod(q) || c !== ref_cnt(1)) begin
      errors++;
      $display("FAIL single_result: ok=%0b data=%0h count=%0d, required data=%0h count=1", ok, d, c, ref_prod(q));
    end
    bad = 0;
    repeat (10) begin
      step();
      if (res_valid !== 1'b1 || res_data !== ref_prod(q) || res_count !== ref_cnt(1)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_hold: %0d of 10 cycles unstable, required 0", bad);
    end
    res_ready = 1'b1;
    step();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_release: res_valid=%0b, required 0", res_valid);
    end
  endtask

  task automatic test_backpressure();
    int qa[$];
    int qb[$];
    bit ok;
    logic [15:0] d;
    logic [CNT_W-1:0] c;
    int vc, bad, n;
    qa.push_back(2); qa.push_back(3);
    qb.push_back(2); qb.push_back(3); qb.push_back(5); qb.push_back(7); qb.push_back(11); qb.push_back(13);
    res_ready = 1'b0;
    send_frame(qa, ok);
    wait_result(50, ok, d, c, vc);
    checks++;
    if (!ok || d !== ref_prod(qa) || c !== ref_cnt(2)) begin
      errors++;
      $display("FAIL bp_first_result: ok=%0b data=%0d count=%0d, required %0d/2", ok, d, c, ref_prod(qa));
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      push_one(8'(qb[i]), 1'b0, ok);
      if (!ok) bad++;
    end
    checks++;
    if (bad != 0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_fill: rejected=%0d in_ready=%0b, required 0 rejected and in_ready=0", bad, in_ready);
    end
    in_data = 8'(qb[4]);
    in_last = 1'b0;
    in_valid = 1'b1;
    bad = 0;
    repeat (5) begin
      step();
      if (in_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== ref_prod(qa)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stall: %0d of 5 cycles wrong, required in_ready=0 with result held", bad);
    end
    res_ready = 1'b1;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (in_ready) break;
    end
    // handshake -> IDLE -> INIT -> RUN pops, so in_ready returns on the fourth cycle
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL bp_ready_return: in_ready high after %0d cycles, required 4", n);
    end
    step();
    in_valid = 1'b0;
    push_one(8'(qb[5]), 1'b1, ok);
    wait_result(60, ok, d, c, vc);
    checks++;
    if (!ok || d !== ref_prod(qb) || c !== ref_cnt(6)) begin
      errors++;
      $display("FAIL bp_second_result: ok=%0b data=%0d count=%0d, required %0d/6", ok, d, c, ref_prod(qb));
    end
    step();
  endtask

  task automatic test_bubbles();
    int q[$];
    bit ok;
    logic [15:0] d;
    logic [CNT_W-1:0] c;
    int vc, start, first_ce, last_ce, ce_cnt;
    q.push_back(2); q.push_back(9);
    res_ready = 1'b1;
    start = cyc;
    push_one(8'(q[0]), 1'b0, ok);
    repeat (8) step();
    push_one(8'(q[1]), 1'b1, ok);
    wait_result(50, ok, d, c, vc);
    checks++;
    if (!ok || d !== ref_prod(q) || c !== ref_cnt(2)) begin
      errors++;
      $display("FAIL bubble_result: ok=%0b data=%0d count=%0d, required %0d/2", ok, d, c, ref_prod(q));
    end
    step();
    first_ce = -1; last_ce = -1; ce_cnt = 0;
    for (int i = start; i <= vc && i < MAXC; i++) begin
      if (ce_log[i]) begin
        if (first_ce < 0) first_ce = i;
        last_ce = i;
        ce_cnt++;
      end
    end
    checks++;
    if (ce_cnt != 2 || last_ce - first_ce < 2) begin
      errors++;
      $display("FAIL bubble_ce: mul_ce cycles=%0d first=%0d last=%0d, required 2 separated by idle cycles", ce_cnt, first_ce, last_ce);
    end
  endtask

  task automatic test_reset_midframe();
    int q[$];
    bit ok;
    logic [15:0] d;
    logic [CNT_W-1:0] c;
    int vc, n;
    res_ready = 1'b1;
    push_one(8'd4, 1'b0, ok);
    push_one(8'd4, 1'b0, ok);
    push_one(8'd4, 1'b1, ok);
    n = 0;
    while (!mul_ce && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (!mul_ce) begin
      errors++;
      $display("FAIL midreset_run: mul_ce=%0b after %0d cycles, required 1", mul_ce, n);
    end
    nReset = 1'b0;
    step();
    checks++;
    if ({in_ready, mul_a, mul_ce, mul_init, res_data, res_count, res_valid} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: in_ready=%0b mul_a=%0h ce=%0b init=%0b res=%0h cnt=%0d valid=%0b, all must be 0",
               in_ready, mul_a, mul_ce, mul_init, res_data, res_count, res_valid);
    end
    step();
    nReset = 1'b1;
    step();
    q.push_back(2); q.push_back(3);
    send_frame(q, ok);
    wait_result(50, ok, d, c, vc);
    checks++;
    if (!ok || d !== ref_prod(q) || c !== ref_cnt(2)) begin
      errors++;
      $display("FAIL midreset_next_frame: ok=%0b data=%0d count=%0d, required %0d/2", ok, d, c, ref_prod(q));
    end
    step();
  endtask

  task automatic test_saturate();
    int q[$];
    bit ok;
    logic [15:0] d;
    logic [CNT_W-1:0] c;
    int vc;
    q.push_back(3);
    repeat (299) q.push_back(1);
    res_ready = 1'b1;
    send_frame(q, ok);
    wait_result(50, ok, d, c, vc);
    checks++;
    if (!ok || d !== ref_prod(q) || c !== ref_cnt(q.size())) begin
      errors++;
      $display("FAIL saturate_result: ok=%0b data=%0d count=%0d, required %0d/%0d", ok, d, c, ref_prod(q), ref_cnt(q.size()));
    end
    step();
  endtask

  task automatic test_random();
    int vals[$];
    int lens[$];
    int fr[$];
    logic [15:0] exp_d[$];
    logic [CNT_W-1:0] exp_c[$];
    int len, v, idx, got, budget;
    bit ok;
    for (int f = 0; f < NF; f++) begin
      len = $urandom_range(1, 6);
      fr.delete();
      for (int k = 0; k < len; k++) begin
        v = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 255));
        fr.push_back(v);
        vals.push_back(v);
      end
      lens.push_back(len);
      exp_d.push_back(ref_prod(fr));
      exp_c.push_back(ref_cnt(len));
    end
    idx = 0;
    got = 0;
    fork
      begin
        foreach (lens[f]) begin
          for (int k = 0; k < lens[f]; k++) begin
            repeat ($urandom_range(0, 2)) step();
            push_one(8'(vals[idx]), (k == lens[f] - 1), ok);
            checks++;
            if (!ok) begin
              errors++;
              $display("FAIL random_push: frame %0d operand %0d accepted=%0b, required 1", f, k, ok);
            end
            idx++;
          end
        end
      end
      begin
        budget = 0;
        while (got < NF && budget < 5000) begin
          @(negedge clk);
          budget++;
          res_ready = 1'($urandom_range(0, 1));
          if (res_valid && res_ready) begin
            checks++;
            if (res_data !== exp_d[got] || res_count !== exp_c[got]) begin
              errors++;
              $display("FAIL random_result: frame %0d data=%0h count=%0d, required data=%0h count=%0d",
                       got, res_data, res_count, exp_d[got], exp_c[got]);
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (got != NF) begin
      errors++;
      $display("FAIL random_complete: %0d results received, required %0d", got, NF);
    end
    res_ready = 1'b1;
    step();
  endtask

  task automatic test_invariants();
    checks++;
    if (overlap_cnt != 0) begin
      errors++;
      $display("FAIL init_ce_overlap: %0d cycles with mul_init and mul_ce both high, required 0", overlap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_truncate();
    test_single_hold();
    test_backpressure();
    test_bubbles();
    test_reset_midframe();
    test_saturate();
    test_random();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
